// File: rtl/hstl_bidir_xfer_ctrl.sv
// rtl/hstl_bidir_xfer_ctrl.sv - half-duplex command/stream controller for a bank of bidirectional HSTL pads
module hstl_bidir_xfer_ctrl #(
  parameter int W      = 8,
  parameter int LW     = 8,
  parameter int TURN   = 2,
  parameter int RD_LAT = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic          CMD_RD,
  input  logic [LW-1:0] CMD_LEN,
  input  logic [W-1:0]  WD_DATA,
  input  logic          WD_VALID,
  output logic          WD_READY,
  output logic [W-1:0]  RD_DATA,
  output logic          RD_VALID,
  output logic [W-1:0]  PAD_I,
  output logic [W-1:0]  PAD_T,
  input  logic [W-1:0]  PAD_O,
  output logic          BUSY
);
  localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;

  typedef enum logic [1:0] {IDLE, TA, WR, RD} state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   cnt, cnt_nxt;
  logic [TW-1:0]   ta_cnt, ta_nxt;
  logic            last_rd, last_rd_nxt;
  logic            pad_t_q, pad_t_nxt;
  logic [W-1:0]    pad_i_nxt;
  logic            rd_sample;
  logic [W-1:0]    rd_pipe [RD_LAT+1];
  logic [RD_LAT:0] vld_pipe;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ta_nxt      = ta_cnt;
    last_rd_nxt = last_rd;
    pad_i_nxt   = PAD_I;
    pad_t_nxt   = 1'b1;
    rd_sample   = 1'b0;
    CMD_READY   = 1'b0;
    WD_READY    = 1'b0;
    case (state)
      IDLE: begin
        CMD_READY = RST_N;
        if (CMD_VALID && RST_N) begin
          cnt_nxt = CMD_LEN;
          if (CMD_RD) begin
            state_nxt = RD;
          end else if (last_rd) begin
            state_nxt = TA;
            ta_nxt    = TW'(TURN - 1);
          end else begin
            state_nxt = WR;
          end
        end
      end
      TA: begin
        if (ta_cnt == '0) begin
          state_nxt   = WR;
          last_rd_nxt = 1'b0;
        end else begin
          ta_nxt = ta_cnt - TW'(1);
        end
      end
      WR: begin
        WD_READY  = 1'b1;
        // stalls keep the pads as they are: released before the first beat, driven after it
        pad_t_nxt = pad_t_q;
        if (WD_VALID) begin
          pad_i_nxt = WD_DATA;
          pad_t_nxt = 1'b0;
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt - LW'(1);
        end
      end
      RD: begin
        rd_sample = 1'b1;
        if (cnt == '0) begin
          state_nxt   = IDLE;
          last_rd_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - LW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      cnt     <= '0;
      ta_cnt  <= '0;
      last_rd <= 1'b0;
      PAD_I   <= '0;
      pad_t_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ta_cnt  <= ta_nxt;
      last_rd <= last_rd_nxt;
      PAD_I   <= pad_i_nxt;
      pad_t_q <= pad_t_nxt;
    end
  end

  // stage 0 is the pad sample register; the beat leaves RD_LAT edges later
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe <= '0;
      for (int i = 0; i <= RD_LAT; i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0]  <= PAD_O;
      vld_pipe[0] <= rd_sample;
      for (int i = 1; i <= RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      vld_pipe[RD_LAT:1] <= vld_pipe[RD_LAT-1:0];
    end
  end

  assign PAD_T    = {W{pad_t_q}};
  assign RD_DATA  = rd_pipe[RD_LAT];
  assign RD_VALID = vld_pipe[RD_LAT];
  assign BUSY     = (state != IDLE) || (|vld_pipe);

endmodule
